// File: rtl/clock_period_meter.sv
// rtl/clock_period_meter.sv - period/high-time meter for a slow clock-like signal with valid/ready results
module clock_period_meter #(
    parameter int unsigned      WIDTH       = 28,
    parameter logic [WIDTH-1:0] TIMEOUT     = 28'd200000000,
    parameter int unsigned      SYNC_STAGES = 2
) (
    input  logic             clock_in,
    input  logic             reset_n,
    input  logic             sig_in,
    input  logic             meas_ready,
    output logic             meas_valid,
    output logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] high_time,
    output logic             overrun,
    output logic             timeout,
    output logic             edge_pulse
);

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] LAST_CNT = TIMEOUT - 1'b1;
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    state_t                 state;
    state_t                 state_nxt;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic [WIDTH-1:0]       cnt;
    logic [WIDTH-1:0]       hcnt;
    logic                   s;
    logic                   rise;
    logic                   xfer;
    logic                   load;
    logic                   to_hit;

    assign s      = sync_q[SYNC_STAGES-1];
    assign rise   = s & ~prev_q;
    assign xfer   = meas_valid & meas_ready;
    assign load   = (state == MEASURE) && rise;
    assign to_hit = (state == MEASURE) && !rise && (cnt == LAST_CNT);

    // Synchronizer and prev reset high so a signal already high at release needs a low first.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
            prev_q <= s;
        end
    end

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (rise) state_nxt = MEASURE;
            MEASURE: if (to_hit) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            cnt        <= '0;
            hcnt       <= '0;
            period     <= '0;
            high_time  <= '0;
            meas_valid <= 1'b0;
            overrun    <= 1'b0;
            timeout    <= 1'b0;
            edge_pulse <= 1'b0;
        end else begin
            edge_pulse <= rise;

            if (rise) begin
                cnt  <= ONE;
                hcnt <= ONE;
            end else if (state == MEASURE) begin
                cnt <= cnt + 1'b1;
                // High time stops accumulating at the falling edge.
                if (s) hcnt <= hcnt + 1'b1;
            end

            if (state == IDLE && rise) begin
                timeout <= 1'b0;
            end else if (to_hit) begin
                timeout <= 1'b1;
            end

            if (load) begin
                period     <= cnt;
                high_time  <= hcnt;
                meas_valid <= 1'b1;
                if (xfer) begin
                    overrun <= 1'b0;
                end else if (meas_valid) begin
                    overrun <= 1'b1;
                end
            end else if (xfer) begin
                meas_valid <= 1'b0;
                overrun    <= 1'b0;
            end
        end
    end

endmodule
